// File: rtl/pipelined_rca_pkg.sv
// pipelined_rca_pkg
// Shared configuration for the pipelined ripple-carry adder:
//   DEFAULT_WIDTH / DEFAULT_SEG - default operand width and bits per stage
//   calc_stages()               - number of pipeline stages for a config
//   legal_cfg()                 - 1 when WIDTH splits evenly into SEG-bit stages
package pipelined_rca_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_SEG   = 4;

  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

  // Short-circuit order matters: the modulo is only evaluated once seg >= 1.
  function automatic bit legal_cfg(input int width, input int seg);
    if (seg < 1) return 1'b0;
    if (width < seg) return 1'b0;
    return (width % seg) == 0;
  endfunction

endpackage

// File: rtl/pipelined_rca_if.sv
// pipelined_rca_if
// Operand / result bus of the pipelined adder.
//   in_valid, in_ready, a, b, cin, sub : operand side
//   out_valid, out_ready, sum, cout, ovf : result side
// Handshake: a side transfers on a rising edge where valid && ready are both 1.
// The producer holds valid and its payload stable until that transfer; ready may
// depend combinationally on the consumer's ready, valid never depends on ready.
// Modports: master = producer of operands and consumer of results (environment),
//           slave  = the adder itself.
interface pipelined_rca_if
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/rca_segment.sv
// rca_segment
// Purely combinational W-bit ripple-carry adder used as one pipeline stage.
//   a, b  : W-bit addends
//   cin   : carry into bit 0
//   s     : W-bit sum
//   cout  : carry out of bit W-1
//   cmsb  : carry into bit W-1 (used for signed overflow in the top stage)
module rca_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  // The carry is a procedural variable rippled bit by bit, so the chain reads
  // as one sequential loop rather than a self-referencing vector.
  always_comb begin : ripple
    logic carry;
    carry = cin;
    s     = '0;
    cmsb  = cin;
    for (int i = 0; i < W; i++) begin
      cmsb  = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_rca.sv
// pipelined_rca
// Ripple-carry adder/subtractor split into STAGES = WIDTH/SEG pipeline stages.
// Stage i adds operand bits [i*SEG +: SEG] with the carry registered by stage i-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipelined_rca_if slave modport
//                sub=0: sum = a + b + cin ; sub=1: sum = a + ~b + 1 (a - b)
//                cout = carry out of the MSB, ovf = signed overflow
// Latency is STAGES cycles, throughput one result per cycle. The whole pipeline
// shares one enable: it advances when the output slot is empty or being taken.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input logic           clk,
  input logic           rst_n,
  pipelined_rca_if.slave bus
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  if (!legal_cfg(WIDTH, SEG)) begin : g_bad_cfg
    $fatal(1, "pipelined_rca: WIDTH must be a positive multiple of SEG");
  end

  logic en;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // Each stage registers: valid bit, carry out, completed low sum bits
  // ((i+1)*SEG of them) and, unless it is the last stage, the operand bits
  // still waiting to be added. Operands shrink as they move up, so every
  // stored bit is consumed by a later stage.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int REM = WIDTH - i * SEG;  // operand bits entering this stage

    logic [REM-1:0]         a_in;
    logic [REM-1:0]         b_in;
    logic                   c_in;
    logic                   v_in;
    logic [SEG-1:0]         seg_s;
    logic                   seg_cout;
    logic                   seg_cmsb;
    logic [(i+1)*SEG-1:0]   sum_d;
    logic [(i+1)*SEG-1:0]   sum_q;
    logic                   v_q;
    logic                   c_q;

    if (i == 0) begin : g_src
      // Subtraction is a + ~b + 1: invert b and force the initial carry.
      assign a_in  = bus.a;
      assign b_in  = bus.b ^ {WIDTH{bus.sub}};
      assign c_in  = bus.sub | bus.cin;
      assign v_in  = bus.in_valid;
      assign sum_d = seg_s;
    end else begin : g_src
      assign a_in  = g_stage[i-1].g_fwd.a_q;
      assign b_in  = g_stage[i-1].g_fwd.b_q;
      assign c_in  = g_stage[i-1].c_q;
      assign v_in  = g_stage[i-1].v_q;
      assign sum_d = {seg_s, g_stage[i-1].sum_q};
    end

    rca_segment #(.W(SEG)) u_seg (
      .a    (a_in[SEG-1:0]),
      .b    (b_in[SEG-1:0]),
      .cin  (c_in),
      .s    (seg_s),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q   <= v_in;
        c_q   <= seg_cout;
        sum_q <= sum_d;
      end
    end

    if (i < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[REM-1:SEG];
          b_q <= b_in[REM-1:SEG];
        end
      end
    end

    if (i == STAGES - 1) begin : g_last
      // Signed overflow: carry into the MSB differs from carry out of it.
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= seg_cmsb ^ seg_cout;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = g_stage[STAGES-1].sum_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca
// Directed bench for pipelined_rca: an 8-bit/4-bit-segment instance (2 stages)
// and a 16-bit/4-bit-segment instance (4 stages) sharing clock and reset.
// Expected results come from a reference adder model and are queued at accept
// time; monitors pop and compare when a result is taken.
module tb_pipelined_rca;

  logic clk;
  logic rst_n;

  pipelined_rca_if #(.WIDTH(8))  bus8 ();
  pipelined_rca_if #(.WIDTH(16)) bus16 ();

  pipelined_rca #(.WIDTH(8), .SEG(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  pipelined_rca #(.WIDTH(16), .SEG(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [17:0] exp8_q[$];
  logic [17:0] exp16_q[$];
  int          out8_cyc[$];
  int          out16_cyc[$];
  int          n_out8 = 0;
  int          n_out16 = 0;
  int          acc8 = 0;
  int          acc16 = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: {ovf, cout, sum} for a w-bit add/subtract (sum zero-extended).
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] mask;
    logic [16:0] tot;
    logic [15:0] bb;
    logic [15:0] s;
    logic        co;
    logic        ov;
    mask = (17'd1 << w) - 17'd1;
    bb   = (sub ? ~b : b) & mask[15:0];
    tot  = {1'b0, a} + {1'b0, bb} + (sub ? 17'd1 : {16'd0, cin});
    s    = tot[15:0] & mask[15:0];
    co   = tot[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      if (exp8_q.size() == 0) begin
        chk("unexpected_out8", 32'd1, 32'd0);
      end else begin
        chk("res8", {14'd0, bus8.ovf, bus8.cout, 8'h00, bus8.sum}, {14'd0, exp8_q.pop_front()});
        out8_cyc.push_back(cyc);
        n_out8++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus16.out_valid && bus16.out_ready) begin
      if (exp16_q.size() == 0) begin
        chk("unexpected_out16", 32'd1, 32'd0);
      end else begin
        chk("res16", {14'd0, bus16.ovf, bus16.cout, bus16.sum}, {14'd0, exp16_q.pop_front()});
        out16_cyc.push_back(cyc);
        n_out16++;
      end
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    bit ok;
    ok = 1'b0;
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.in_valid = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      exp8_q.push_back(model(8, {8'h00, a}, {8'h00, b}, cin, sub));
      acc8 = cyc;
    end else begin
      chk("send8_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    bit ok;
    ok = 1'b0;
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub; bus16.in_valid = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus16.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      exp16_q.push_back(model(16, a, b, cin, sub));
      acc16 = cyc;
    end else begin
      chk("send16_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
  endtask

  task automatic drain8();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (exp8_q.size() == 0) break;
    end
    chk("drain8", exp8_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain16();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (exp16_q.size() == 0) break;
    end
    chk("drain16", exp16_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  a0;
    int  n0;
    bit  seen;

    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    bus8.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_out_valid8", bus8.out_valid, 32'd0);
    chk("rst_in_ready8", bus8.in_ready, 32'd1);
    chk("rst_sum8", {bus8.ovf, bus8.cout, bus8.sum}, 32'd0);
    chk("rst_out_valid16", bus16.out_valid, 32'd0);
    chk("rst_in_ready16", bus16.in_ready, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", bus8.in_ready, 32'd1);

    // Basic adds and 2-cycle latency
    out8_cyc.delete();
    send8(8'h01, 8'h00, 1'b1, 1'b0);
    a0 = acc8;
    drain8();
    chk("lat8", (out8_cyc.size() > 0) ? out8_cyc[0] : -1, a0 + 2);
    send8(8'h39, 8'h87, 1'b1, 1'b0);
    drain8();

    // Carry, overflow and subtraction corners, back to back
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    send8(8'h7F, 8'h01, 1'b0, 1'b0);
    send8(8'hFF, 8'h81, 1'b1, 1'b0);
    send8(8'h05, 8'h07, 1'b1, 1'b1);  // cin ignored when subtracting
    send8(8'h80, 8'h01, 1'b0, 1'b1);
    drain8();

    // Four back-to-back transactions: results on consecutive cycles
    out8_cyc.delete();
    for (int j = 0; j < 4; j++) begin
      send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (j == 0) a0 = acc8;
    end
    drain8();
    chk("b2b_count", out8_cyc.size(), 32'd4);
    for (int j = 0; j < out8_cyc.size(); j++) chk("b2b_cycle", out8_cyc[j], a0 + 2 + j);

    // Output stall for 5 cycles with 3 transactions offered
    bus8.out_ready = 1'b0;
    n0 = n_out8;
    fork
      begin
        send8(8'h11, 8'h22, 1'b0, 1'b0);
        send8(8'hF0, 8'h0F, 1'b1, 1'b0);
        send8(8'h40, 8'h41, 1'b0, 1'b1);
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (bus8.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        chk("stall_seen", seen, 32'd1);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk("stall_in_ready", bus8.in_ready, 32'd0);
          chk("stall_out_valid", bus8.out_valid, 32'd1);
          chk("stall_hold", {14'd0, bus8.ovf, bus8.cout, 8'h00, bus8.sum},
              (exp8_q.size() > 0) ? {14'd0, exp8_q[0]} : 32'hFFFF_FFFF);
        end
        @(posedge clk); #1;
        bus8.out_ready = 1'b1;
      end
    join
    drain8();
    chk("stall_count", n_out8 - n0, 32'd3);

    // Reset with two transactions in flight
    send8(8'hAA, 8'h01, 1'b0, 1'b0);
    send8(8'h55, 8'h02, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus8.out_valid, 32'd0);
    chk("midrst_outputs", {bus8.ovf, bus8.cout, bus8.sum}, 32'd0);
    exp8_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", bus8.in_ready, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out8_cyc.delete();
    n0 = n_out8;
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    a0 = acc8;
    drain8();
    repeat (4) @(negedge clk);
    chk("postrst_count", n_out8 - n0, 32'd1);
    chk("postrst_lat", (out8_cyc.size() > 0) ? out8_cyc[0] : -1, a0 + 2);
    @(posedge clk); #1;

    // 16-bit, 4-stage instance
    out16_cyc.delete();
    send16(16'h0001, 16'h0000, 1'b1, 1'b0);
    a0 = acc16;
    drain16();
    chk("lat16", (out16_cyc.size() > 0) ? out16_cyc[0] : -1, a0 + 4);
    send16(16'h0039, 16'h0087, 1'b1, 1'b0);
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send16(16'h8000, 16'h0001, 1'b0, 1'b1);
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain16();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 Parameter WIDTH, default 8, operand/sum width in bits.
REQ-002 Parameter SEG, default 4, bits added per pipeline stage; WIDTH SHALL be a multiple of SEG, SEG >= 1; STAGES = WIDTH/SEG.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH each  operands, two's-complement or unsigned.
REQ-008 cin  input  1  carry-in; ignored when sub=1.
REQ-009 sub  input  1  0: a+b+cin; 1: a+~b+1 (a-b).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 sum  output  WIDTH  result bits; cout output 1 carry out of MSB; ovf output 1 signed overflow.

Function
REQ-013 Transfer on input side SHALL occur when in_valid && in_ready, on output side when out_valid && out_ready.
REQ-014 Pipeline enable en = !out_valid || out_ready; in_ready SHALL equal en; all stage registers advance only when en=1.
REQ-015 Stage i (0..STAGES-1) SHALL add bits [i*SEG +: SEG] of a and b-or-~b with the carry registered by stage i-1 (stage 0 uses cin, or 1 when sub=1); unprocessed upper operand bits and completed lower sum bits SHALL be carried forward in stage registers.
REQ-016 Latency SHALL be exactly STAGES cycles: operands accepted at edge k yield out_valid=1 after edge k+STAGES-1 when no stall occurs.
REQ-017 Throughput SHALL be one result per cycle while out_ready=1.
REQ-018 Each stage SHALL carry a valid bit; bubbles (in_valid=0 with en=1) SHALL propagate as invalid slots, not be collapsed.
REQ-019 When out_valid=1 and out_ready=0, all stages, sum, cout, ovf SHALL hold and in_ready SHALL be 0; no transaction lost or duplicated.
REQ-020 cout SHALL be the carry out of bit WIDTH-1; for sub=1 cout=1 means no borrow.
REQ-021 ovf SHALL equal carry into bit WIDTH-1 XOR cout.
REQ-022 Results SHALL be correct modulo 2^WIDTH, including all-ones + 1 wrap-around.
REQ-023 sum/cout/ovf SHALL be meaningful only when out_valid=1 but SHALL be registered (no combinational path from inputs to outputs); in_ready may depend combinationally on out_ready.

Reset
REQ-024 rst_n=0 SHALL immediately clear all stage valid bits, out_valid, sum, cout, ovf to 0, independent of clk.
REQ-025 Reset mid-operation SHALL discard every in-flight transaction; first result after release SHALL come from operands accepted after release.
REQ-026 in_ready SHALL be 1 during and directly after reset (pipeline empty).

Structure
REQ-027 Shared package pipelined_rca_pkg SHALL hold DEFAULT_WIDTH=8, DEFAULT_SEG=4 and the STAGES = WIDTH/SEG derivation; legality check of WIDTH % SEG SHALL fail elaboration.
REQ-028 One combinational sub-module rca_segment (SEG-bit ripple-carry adder: a, b, cin -> s, cout, carry into MSB) SHALL be instantiated once per stage via generate.

Verification (WIDTH=8, SEG=4, STAGES=2)
REQ-029 a=0x01,b=0x00,cin=1,sub=0 -> after 2 cycles sum=0x02,cout=0,ovf=0; a=0x39,b=0x87,cin=1 -> sum=0xC1,cout=0,ovf=0.
REQ-030 a=0xFF,b=0x01,cin=0 -> sum=0x00,cout=1,ovf=0; a=0x7F,b=0x01,cin=0 -> sum=0x80,cout=0,ovf=1; a=0xFF,b=0x81,cin=1 -> sum=0x81,cout=1,ovf=0.
REQ-031 sub=1,a=0x05,b=0x07 -> sum=0xFE,cout=0,ovf=0; sub=1,a=0x80,b=0x01 -> sum=0x7F,cout=1,ovf=1.
REQ-032 Back-to-back 4 transactions with out_ready=1 -> 4 results on 4 consecutive cycles, in order, first 2 cycles after first accept.
REQ-033 out_ready=0 for 5 cycles with 3 accepted -> in_ready=0 once out_valid=1, outputs stable, then all 3 results delivered in order when out_ready=1.
REQ-034 rst_n pulsed low with 2 transactions in flight -> out_valid=0 immediately, neither result ever appears; a new transaction after release returns correctly after 2 cycles; repeat REQ-029 with WIDTH=16,SEG=4 (latency 4).
